noc_local_injector: RTL

Network-interface injection stage feeding the router's local port (port 4). It takes payload beats from a local core over a valid/ready stream, prepends a routing head flit, and emits 35-bit flits on the router's local IDATA/IVALID/IVCH inputs. Per-VC credit-based flow control is driven by the router's OACK returns, and the block drives the per-VC ILCK hold signals for the duration of each packet.

---
 rtl/noc_local_injector.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/noc_local_injector.sv
// NoC local-port injection stage: prepends a routing head flit to each core packet,
// enforces per-VC credit flow control and holds the per-VC lock for the packet's lifetime.
module noc_local_injector #(
    parameter int BUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  MY_XPOS,
    input  logic [1:0]  MY_YPOS,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    input  logic        s_last,
    input  logic [1:0]  s_dst_x,
    input  logic [1:0]  s_dst_y,
    input  logic        s_vch,
    output logic [34:0] inj_DATA,
    output logic        inj_VALID,
    output logic        inj_VCH,
    output logic [1:0]  inj_LCK,
    input  logic [1:0]  inj_ACK,
    output logic        err
);

    localparam logic [3:0] CRED_MAX  = 4'(BUF_DEPTH);
    localparam logic [2:0] TYPE_HEAD = 3'b001;
    localparam logic [2:0] TYPE_BODY = 3'b010;
    localparam logic [2:0] TYPE_TAIL = 3'b011;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_vc;
    logic [3:0]  r_cred [2];
    logic        r_err;
    logic [34:0] r_data;
    logic        r_valid;
    logic        r_vch;
    logic [1:0]  r_lck;

    logic        w_start;
    logic        w_beat;
    logic        w_send;
    logic [34:0] w_flit;
    logic        w_flit_vc;
    logic [1:0]  w_lck;
    logic [1:0]  w_dec;

    // Credit checks look only at registered counters, so an ack is usable one cycle later.
    assign w_start = (r_state == ST_IDLE) && s_valid && (r_cred[s_vch] != 4'd0);
    assign s_ready = (r_state == ST_BODY) && (r_cred[r_vc] != 4'd0);
    assign w_beat  = s_valid && s_ready;

    // State register and VC latch for the packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_vc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_vc <= s_vch;
            end else begin
                r_vc <= r_vc;
            end
        end
    end

    // Next-state logic: head launches the packet, the tail beat closes it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_BODY;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BODY: begin
                if (w_beat && s_last) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_BODY;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: next flit, its VC and the next lock vector.
    always_comb begin
        w_send    = 1'b0;
        w_flit    = r_data;
        w_flit_vc = r_vch;
        w_lck     = 2'b00;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_send    = 1'b1;
                    w_flit    = {TYPE_HEAD, s_dst_x, s_dst_y, MY_XPOS, MY_YPOS, 24'h00_0000};
                    w_flit_vc = s_vch;
                    w_lck     = {s_vch, ~s_vch};
                end else begin
                    w_lck     = 2'b00;
                end
            end
            ST_BODY: begin
                // Lock stays set through the tail cycle, including stalls.
                w_lck = {r_vc, ~r_vc};
                if (w_beat) begin
                    w_send    = 1'b1;
                    w_flit    = {(s_last ? TYPE_TAIL : TYPE_BODY), s_data};
                    w_flit_vc = r_vc;
                end else begin
                    w_send    = 1'b0;
                end
            end
            default: begin
                w_send = 1'b0;
                w_lck  = 2'b00;
            end
        endcase
    end

    assign w_dec = w_send ? {w_flit_vc, ~w_flit_vc} : 2'b00;

    // Per-VC credit counters; an ack at full credit is dropped and flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cred[0] <= CRED_MAX;
            r_cred[1] <= CRED_MAX;
            r_err     <= 1'b0;
        end else begin
            for (int v = 0; v < 2; v++) begin
                case ({w_dec[v], inj_ACK[v]})
                    2'b10:   r_cred[v] <= r_cred[v] - 4'd1;
                    2'b01: begin
                        if (r_cred[v] == CRED_MAX) begin
                            r_err <= 1'b1;
                        end else begin
                            r_cred[v] <= r_cred[v] + 4'd1;
                        end
                    end
                    default: r_cred[v] <= r_cred[v];
                endcase
            end
        end
    end

    // Registered flit outputs; data and VC hold between flits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= 35'd0;
            r_valid <= 1'b0;
            r_vch   <= 1'b0;
            r_lck   <= 2'b00;
        end else begin
            r_data  <= w_flit;
            r_valid <= w_send;
            r_vch   <= w_flit_vc;
            r_lck   <= w_lck;
        end
    end

    assign inj_DATA  = r_data;
    assign inj_VALID = r_valid;
    assign inj_VCH   = r_vch;
    assign inj_LCK   = r_lck;
    assign err       = r_err;

endmodule
